// File: rtl/grid_game_pkg.sv
// Shared types for the grid game engine: FSM states, scan directions with
// their (row, col) step table, and a width helper for indices and cell values.
package grid_game_pkg;

  typedef enum logic [1:0] {PLAY, CHECK, DONE} gameState_t;

  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;

  // Positive-ray step per direction; the negative ray uses the negated step.
  localparam int DIR_DR [4] = '{0, 1, 1, 1};
  localparam int DIR_DC [4] = '{1, 0, 1, -1};

  // Bits needed to hold the values 0..n-1 (never less than one).
  function automatic int widthFor(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grid_line_scanner.sv
// Sequential K-in-a-row detector: walks a + and - ray per direction from the
// placed cell, one cell per cycle, and reports done/win.
module grid_line_scanner
  import grid_game_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int WIN_LEN = 4,
  parameter int NUM_PLAYERS = 2,
  localparam int PW = widthFor(NUM_PLAYERS + 1),
  localparam int RW = widthFor(ROWS),
  localparam int CW = widthFor(COLS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [RW-1:0]             startRow,
  input  logic [CW-1:0]             startCol,
  input  logic [PW-1:0]             player,
  input  logic [ROWS*COLS*PW-1:0]   board,
  output logic                      done,
  output logic                      win
);

  localparam int SW = widthFor(WIN_LEN);
  localparam int NW = widthFor(WIN_LEN + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIN_LEN - 2);
  localparam logic [NW-1:0] WIN_PRE = NW'(WIN_LEN - 1);

  logic active, negSide;
  dir_t dir, dirNext;
  logic [RW-1:0] originR;
  logic [CW-1:0] originC;
  logic [PW-1:0] placer, cellVal;
  logic signed [RW:0] rayR, dR, pR, dRn, oR, sR, hR;
  logic signed [CW:0] rayC, dC, pC, dCn, oC, sC, hC;
  logic [SW-1:0] steps;
  logic [NW-1:0] count;
  logic inBounds, hit, lastStep, winNow, rayEnd;
  int cellIdx;

  always_comb begin
    dirNext = dir_t'(dir + 2'd1);
    pR = (RW+1)'(DIR_DR[dir]);
    pC = (CW+1)'(DIR_DC[dir]);
    dR = (RW+1)'(negSide ? -DIR_DR[dir] : DIR_DR[dir]);
    dC = (CW+1)'(negSide ? -DIR_DC[dir] : DIR_DC[dir]);
    dRn = (RW+1)'(DIR_DR[dirNext]);
    dCn = (CW+1)'(DIR_DC[dirNext]);
    hR = (RW+1)'(DIR_DR[DIR_H]);
    hC = (CW+1)'(DIR_DC[DIR_H]);
    oR = $signed({1'b0, originR});
    oC = $signed({1'b0, originC});
    sR = $signed({1'b0, startRow});
    sC = $signed({1'b0, startCol});
    inBounds = (int'(rayR) >= 0) && (int'(rayR) < ROWS) &&
               (int'(rayC) >= 0) && (int'(rayC) < COLS);
    cellIdx = int'(rayR) * COLS + int'(rayC);
    cellVal = '0;
    if (inBounds) cellVal = board[cellIdx*PW +: PW];
    hit = active && inBounds && (cellVal == placer);
    lastStep = (steps == LAST_STEP);
    winNow = hit && (count == WIN_PRE);
    // A ray ends on a miss or once it has taken its WIN_LEN-1 steps.
    rayEnd = active && !winNow && (!hit || lastStep);
    done = winNow || (rayEnd && (dir == DIR_A) && negSide);
    win = winNow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      negSide <= 1'b0;
      dir <= DIR_H;
      originR <= '0;
      originC <= '0;
      placer <= '0;
      rayR <= '0;
      rayC <= '0;
      steps <= '0;
      count <= '0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      negSide <= 1'b0;
      dir <= DIR_H;
      originR <= startRow;
      originC <= startCol;
      placer <= player;
      rayR <= sR + hR;
      rayC <= sC + hC;
      steps <= '0;
      count <= NW'(1);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else if (hit && !lastStep) begin
        rayR <= rayR + dR;
        rayC <= rayC + dC;
        steps <= steps + 1'b1;
        count <= count + 1'b1;
      end else if (rayEnd) begin
        if (hit) count <= count + 1'b1;
        steps <= '0;
        if (!negSide) begin
          negSide <= 1'b1;
          rayR <= oR - pR;
          rayC <= oC - pC;
        end else begin
          negSide <= 1'b0;
          dir <= dirNext;
          rayR <= oR + dRn;
          rayC <= oC + dCn;
          count <= NW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/grid_game_engine.sv
// R x C, N-player K-in-a-row game engine: board, cursor, turns, win/draw.
// Define WRAP_CURSOR_EN to make the cursor wrap at board edges instead of saturating.
module grid_game_engine
  import grid_game_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int WIN_LEN = 4,
  parameter int NUM_PLAYERS = 2,
  localparam int PW = widthFor(NUM_PLAYERS + 1),
  localparam int RW = widthFor(ROWS),
  localparam int CW = widthFor(COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     place,
  input  logic                     new_game,
  output logic [ROWS*COLS*PW-1:0]  board,
  output logic [RW-1:0]            cursor_row,
  output logic [CW-1:0]            cursor_col,
  output logic [PW-1:0]            cur_player,
  output logic                     busy,
  output logic                     game_over,
  output logic [PW-1:0]            winner,
  output logic                     game_done
);

  localparam int MW = widthFor(ROWS*COLS + 1);
  localparam logic [MW-1:0] FULL = MW'(ROWS*COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS);
`ifdef WRAP_CURSOR_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  gameState_t state, stateNext;
  logic [ROWS*COLS*PW-1:0] boardQ;
  logic [RW-1:0] rowQ, rowNext;
  logic [CW-1:0] colQ, colNext;
  logic [PW-1:0] curPlayer, starter, winnerQ, cellAtCursor;
  logic [MW-1:0] moveCnt;
  logic doneQ, doPlace, doAdvance, doFinish, scanDone, scanWin;
  int cursorIdx;

  function automatic logic [PW-1:0] nextPlayer(input logic [PW-1:0] p);
    return (p == LAST_PLAYER) ? PW'(1) : p + 1'b1;
  endfunction

  grid_line_scanner #(
    .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .NUM_PLAYERS(NUM_PLAYERS)
  ) scanner (
    .clk(clk), .rst(rst), .start(doPlace), .abort(new_game),
    .startRow(rowQ), .startCol(colQ), .player(curPlayer), .board(boardQ),
    .done(scanDone), .win(scanWin)
  );

  always_comb begin
    cursorIdx = int'(rowQ) * COLS + int'(colQ);
    cellAtCursor = boardQ[cursorIdx*PW +: PW];
    stateNext = state;
    rowNext = rowQ;
    colNext = colQ;
    doPlace = 1'b0;
    doAdvance = 1'b0;
    doFinish = 1'b0;
    case (state)
      PLAY: begin
        if (place) begin
          if (cellAtCursor == '0) begin
            doPlace = 1'b1;
            stateNext = CHECK;
          end
        end else if (btn_left) colNext = (colQ == '0) ? (WRAP ? COL_MAX : '0) : colQ - 1'b1;
        else if (btn_right) colNext = (colQ == COL_MAX) ? (WRAP ? '0 : COL_MAX) : colQ + 1'b1;
        else if (btn_up) rowNext = (rowQ == '0) ? (WRAP ? ROW_MAX : '0) : rowQ - 1'b1;
        else if (btn_down) rowNext = (rowQ == ROW_MAX) ? (WRAP ? '0 : ROW_MAX) : rowQ + 1'b1;
      end
      CHECK: begin
        if (scanDone) begin
          if (scanWin || (moveCnt == FULL)) begin
            doFinish = 1'b1;
            stateNext = DONE;
          end else begin
            doAdvance = 1'b1;
            stateNext = PLAY;
          end
        end
      end
      default: ;
    endcase
    // new_game overrides everything, including an in-flight scan.
    if (new_game) begin
      stateNext = PLAY;
      rowNext = '0;
      colNext = '0;
      doPlace = 1'b0;
      doAdvance = 1'b0;
      doFinish = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PLAY;
      boardQ <= '0;
      rowQ <= '0;
      colQ <= '0;
      curPlayer <= PW'(1);
      starter <= PW'(1);
      moveCnt <= '0;
      winnerQ <= '0;
      doneQ <= 1'b0;
    end else begin
      state <= stateNext;
      rowQ <= rowNext;
      colQ <= colNext;
      doneQ <= (stateNext == DONE) && (state != DONE);
      if (new_game) begin
        boardQ <= '0;
        moveCnt <= '0;
        winnerQ <= '0;
        starter <= nextPlayer(starter);
        curPlayer <= nextPlayer(starter);
      end else begin
        if (doPlace) begin
          boardQ[cursorIdx*PW +: PW] <= curPlayer;
          moveCnt <= moveCnt + 1'b1;
        end
        if (doAdvance) curPlayer <= nextPlayer(curPlayer);
        if (doFinish) winnerQ <= scanWin ? curPlayer : '0;
      end
    end
  end

  assign board = boardQ;
  assign cursor_row = rowQ;
  assign cursor_col = colQ;
  assign cur_player = curPlayer;
  assign busy = (state == CHECK);
  assign game_over = (state == DONE);
  assign winner = winnerQ;
  assign game_done = doneQ;

endmodule

// File: tb/tb_grid_game_engine.sv
// Bench for grid_game_engine: a 5x5/K=4 and a 3x3/K=3 instance driven by directed
// and random button sequences, checked against a cell-array game model.
module tb_grid_game_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic bl[2], br[2], bu[2], bd[2], pl[2], ng[2];

  logic [49:0] board0;
  logic [2:0]  row0, col0;
  logic [1:0]  cp0, win0;
  logic        busy0, over0, done0;
  logic [17:0] board1;
  logic [1:0]  row1, col1;
  logic [1:0]  cp1, win1;
  logic        busy1, over1, done1;

  grid_game_engine dut0 (
    .clk(clk), .rst(rst),
    .btn_left(bl[0]), .btn_right(br[0]), .btn_up(bu[0]), .btn_down(bd[0]),
    .place(pl[0]), .new_game(ng[0]),
    .board(board0), .cursor_row(row0), .cursor_col(col0), .cur_player(cp0),
    .busy(busy0), .game_over(over0), .winner(win0), .game_done(done0)
  );

  grid_game_engine #(.ROWS(3), .COLS(3), .WIN_LEN(3), .NUM_PLAYERS(2)) dut1 (
    .clk(clk), .rst(rst),
    .btn_left(bl[1]), .btn_right(br[1]), .btn_up(bu[1]), .btn_down(bd[1]),
    .place(pl[1]), .new_game(ng[1]),
    .board(board1), .cursor_row(row1), .cursor_col(col1), .cur_player(cp1),
    .busy(busy1), .game_over(over1), .winner(win1), .game_done(done1)
  );

`ifdef WRAP_CURSOR_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int NP = 2;

  int R[2] = '{5, 3};
  int C[2] = '{5, 3};
  int W[2] = '{4, 3};
  int mb[2][8][8];
  int mRow[2], mCol[2], mPlayer[2], mStarter[2], mMoves[2], mOver[2], mWinner[2];
  int vecCnt = 0;
  int errCnt = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nextP(input int p);
    return (p % NP) + 1;
  endfunction

  task automatic clearBoard(input int u);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[u][r][c] = 0;
    mMoves[u] = 0; mRow[u] = 0; mCol[u] = 0; mOver[u] = 0; mWinner[u] = 0;
  endtask

  task automatic modelReset(input int u);
    clearBoard(u);
    mPlayer[u] = 1;
    mStarter[u] = 1;
  endtask

  function automatic bit lineWin(input int u, input int r, input int c, input int p);
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      for (int s = -1; s <= 1; s += 2)
        for (int k = 1; k < W[u]; k++) begin
          int rr = r + s * k * drs[d];
          int cc = c + s * k * dcs[d];
          if (rr < 0 || rr >= R[u] || cc < 0 || cc >= C[u] || mb[u][rr][cc] != p) break;
          n++;
        end
      if (n >= W[u]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] modelBoard(input int u);
    logic [63:0] v = '0;
    for (int r = 0; r < R[u]; r++)
      for (int c = 0; c < C[u]; c++) v[(r*C[u]+c)*2 +: 2] = 2'(mb[u][r][c]);
    return v;
  endfunction

  function automatic logic busyOf(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  task automatic checkAll(input int u, input int expDone);
    logic [63:0] b;
    int rr, cc, cp, bz, ov, wn, dn;
    if (u == 0) begin
      b = 64'(board0); rr = int'(row0); cc = int'(col0); cp = int'(cp0);
      bz = int'(busy0); ov = int'(over0); wn = int'(win0); dn = int'(done0);
    end else begin
      b = 64'(board1); rr = int'(row1); cc = int'(col1); cp = int'(cp1);
      bz = int'(busy1); ov = int'(over1); wn = int'(win1); dn = int'(done1);
    end
    checkVal($sformatf("u%0d.board", u), b, modelBoard(u));
    checkVal($sformatf("u%0d.cursor_row", u), 64'(rr), 64'(mRow[u]));
    checkVal($sformatf("u%0d.cursor_col", u), 64'(cc), 64'(mCol[u]));
    checkVal($sformatf("u%0d.cur_player", u), 64'(cp), 64'(mPlayer[u]));
    checkVal($sformatf("u%0d.busy", u), 64'(bz), 64'(0));
    checkVal($sformatf("u%0d.game_over", u), 64'(ov), 64'(mOver[u]));
    checkVal($sformatf("u%0d.winner", u), 64'(wn), 64'(mWinner[u]));
    checkVal($sformatf("u%0d.game_done", u), 64'(dn), 64'(expDone));
  endtask

  // One input cycle on instance u, then model update and full output check.
  task automatic step(input int u, input bit l, input bit r, input bit up, input bit dn,
                      input bit p, input bit n, input bit waitRes);
    bit placed = 1'b0;
    int lat;
    @(negedge clk);
    bl[u] = l; br[u] = r; bu[u] = up; bd[u] = dn; pl[u] = p; ng[u] = n;
    @(negedge clk);
    bl[u] = 0; br[u] = 0; bu[u] = 0; bd[u] = 0; pl[u] = 0; ng[u] = 0;
    if (n) begin
      clearBoard(u);
      mStarter[u] = nextP(mStarter[u]);
      mPlayer[u] = mStarter[u];
    end else if (mOver[u] == 0) begin
      if (p) begin
        if (mb[u][mRow[u]][mCol[u]] == 0) begin
          mb[u][mRow[u]][mCol[u]] = mPlayer[u];
          mMoves[u]++;
          placed = 1'b1;
        end
      end else if (l) mCol[u] = (mCol[u] == 0) ? (WRAP ? C[u]-1 : 0) : mCol[u]-1;
      else if (r) mCol[u] = (mCol[u] == C[u]-1) ? (WRAP ? 0 : C[u]-1) : mCol[u]+1;
      else if (up) mRow[u] = (mRow[u] == 0) ? (WRAP ? R[u]-1 : 0) : mRow[u]-1;
      else if (dn) mRow[u] = (mRow[u] == R[u]-1) ? (WRAP ? 0 : R[u]-1) : mRow[u]+1;
    end
    if (!placed) begin
      checkAll(u, 0);
      return;
    end
    checkVal($sformatf("u%0d.enter_check", u), 64'(busyOf(u)), 64'(1));
    if (!waitRes) return;
    lat = 0;
    while (busyOf(u) && lat <= 8*(W[u]-1)) begin
      @(negedge clk);
      lat++;
    end
    checkVal($sformatf("u%0d.latency_in_bound(lat=%0d)", u, lat),
             64'(lat <= 8*(W[u]-1) && !busyOf(u)), 64'(1));
    if (lineWin(u, mRow[u], mCol[u], mPlayer[u])) begin
      mOver[u] = 1; mWinner[u] = mPlayer[u];
    end else if (mMoves[u] == R[u]*C[u]) begin
      mOver[u] = 1; mWinner[u] = 0;
    end else begin
      mPlayer[u] = nextP(mPlayer[u]);
    end
    checkAll(u, mOver[u]);
  endtask

  task automatic goTo(input int u, input int r, input int c);
    while (mRow[u] > r) step(u, 0, 0, 1, 0, 0, 0, 1);
    while (mRow[u] < r) step(u, 0, 0, 0, 1, 0, 0, 1);
    while (mCol[u] > c) step(u, 1, 0, 0, 0, 0, 0, 1);
    while (mCol[u] < c) step(u, 0, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic placeAt(input int u, input int r, input int c);
    goTo(u, r, c);
    step(u, 0, 0, 0, 0, 1, 0, 1);
  endtask

  int t1[14] = '{0,0, 1,0, 0,1, 1,1, 0,2, 1,2, 0,3};
  int t2[14] = '{0,3, 4,4, 3,0, 4,3, 2,1, 4,1, 1,2};
  int t4[18] = '{0,0, 0,1, 0,2, 1,1, 1,0, 1,2, 2,1, 2,0, 2,2};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      bl[u] = 0; br[u] = 0; bu[u] = 0; bd[u] = 0; pl[u] = 0; ng[u] = 0;
      modelReset(u);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkAll(0, 0);
    checkAll(1, 0);

    // Edge move at (0,0), then left+place together acts as place only.
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    // Place on the occupied cell is ignored.
    step(0, 0, 0, 0, 0, 1, 0, 1);

    // Reset in the middle of a scan.
    goTo(0, 2, 2);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    modelReset(0);
    modelReset(1);
    checkAll(0, 0);
    checkAll(1, 0);
    @(negedge clk);
    rst = 1'b0;

    // new_game in the middle of a scan rotates the starter.
    goTo(0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Row win for player 1, then inputs in DONE are ignored.
    step(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) placeAt(0, t1[2*i], t1[2*i+1]);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 1);

    // Anti-diagonal win for player 2, completed in the middle of the line.
    step(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) placeAt(0, t2[2*i], t2[2*i+1]);

    // 3x3 draw.
    for (int i = 0; i < 9; i++) placeAt(1, t4[2*i], t4[2*i+1]);

    for (int u = 0; u < 2; u++) begin
      step(u, 0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 200; i++) begin
        bit n = ($urandom_range(0, 39) == 0) || (mOver[u] != 0 && $urandom_range(0, 2) == 0);
        step(u, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, n, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
